// File: rtl/run_step_ctrl.sv
// Execution controller for the single-cycle CPU: debounced run/step/stop buttons,
// breakpoint and halt-opcode detection, PC hold control and a retired-instruction counter.
module run_step_ctrl #(
    parameter int DB_CNT = 1000000,
    parameter int DB_W   = 20
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        btn_stop,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_cur,
    input  logic        halt_insn,
    output logic        halt,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);

    localparam logic [2:0] S_HALTED = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_BREAK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0] btn_raw;
    wire  [2:0] press;

    assign btn_raw = {btn_stop, btn_step, btn_run};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_q, sync1_d;
            logic            sync2_q, sync2_d;
            logic            db_q, db_d;
            logic            pulse_q, pulse_d;
            logic [DB_W-1:0] cnt_q, cnt_d;

            always_comb begin
                sync1_d = btn_raw[gi];
                sync2_d = sync1_q;
                cnt_d   = '0;
                db_d    = db_q;
                pulse_d = 1'b0;
                if (sync2_q != db_q) begin
                    if (cnt_q == DB_W'(DB_CNT - 1)) begin
                        db_d    = sync2_q;
                        pulse_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (Reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    db_q    <= 1'b0;
                    pulse_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    db_q    <= db_d;
                    pulse_q <= pulse_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign press[gi] = pulse_q;
        end
    endgenerate

    logic        run_p, step_p, stop_p;
    logic        bp_hit;
    logic        halt_c;
    logic [2:0]  state_q, state_d;
    logic        skip_q, skip_d;
    logic [15:0] instr_q, instr_d;

    assign run_p  = press[0];
    assign step_p = press[1];
    assign stop_p = press[2];

    // skip suppresses the breakpoint for the first RUN cycle so a resume can leave it
    assign bp_hit = bp_en && (pc_cur == bp_addr) && !skip_q;

    always_comb begin
        state_d = state_q;
        halt_c  = 1'b1;
        case (state_q)
            S_HALTED: begin
                if (run_p)       state_d = S_RUN;
                else if (step_p) state_d = S_STEP;
            end
            S_RUN: begin
                halt_c = halt_insn | bp_hit | stop_p;
                if (halt_insn)   state_d = S_DONE;
                else if (bp_hit) state_d = S_BREAK;
                else if (stop_p) state_d = S_HALTED;
            end
            S_STEP: begin
                halt_c  = halt_insn;
                state_d = halt_insn ? S_DONE : S_HALTED;
            end
            S_BREAK: begin
                if (run_p)       state_d = S_RUN;
                else if (step_p) state_d = S_STEP;
                else if (stop_p) state_d = S_HALTED;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_HALTED;
        endcase

        skip_d = skip_q;
        if (state_d == S_RUN && state_q != S_RUN) skip_d = 1'b1;
        else if (state_q == S_RUN)                skip_d = 1'b0;

        instr_d = halt_c ? instr_q : instr_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_HALTED;
            skip_q  <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            instr_q <= instr_d;
        end
    end

    assign halt        = halt_c;
    assign state       = state_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_run_step_ctrl.sv
// Directed bench for run_step_ctrl with DB_CNT=4: a button press becomes a pulse
// 6 edges after it is applied and the FSM acts on it at the 7th edge.
module tb_run_step_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic        btn_run, btn_step, btn_stop;
    logic        bp_en;
    logic [31:0] bp_addr, pc_cur;
    logic        halt_insn;
    logic        halt;
    logic [2:0]  state;
    logic [15:0] instr_count;

    int errors = 0;
    int checks = 0;

    run_step_ctrl #(.DB_CNT(4), .DB_W(20)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .btn_run     (btn_run),
        .btn_step    (btn_step),
        .btn_stop    (btn_stop),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc_cur      (pc_cur),
        .halt_insn   (halt_insn),
        .halt        (halt),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-20s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
    endtask

    task automatic release_all();
        btn_run = 1'b0; btn_step = 1'b0; btn_stop = 1'b0;
        tick(8);
    endtask

    initial begin
        Reset = 1'b1; btn_run = 0; btn_step = 0; btn_stop = 0;
        bp_en = 0; bp_addr = 32'h0; pc_cur = 32'h0; halt_insn = 0;
        tick(3);
        chk("rst_state", state, 0);
        chk("rst_halt", halt, 1);
        chk("rst_count", instr_count, 0);
        Reset = 1'b0;

        // Run press: pulse after 6 edges, RUN after 7
        btn_run = 1'b1;
        tick(6);
        chk("run_pre_state", state, 0);
        tick(1);
        chk("run_state", state, 1);
        chk("run_halt", halt, 0);
        chk("run_count0", instr_count, 0);
        tick(1);
        chk("run_count1", instr_count, 1);
        tick(1);
        chk("run_count2", instr_count, 2);
        tick(1);
        release_all();
        chk("run_held_state", state, 1);
        chk("run_count11", instr_count, 11);

        // Two single steps
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            btn_step = 1'b1;
            tick(7);
            chk("step_state", state, 2);
            chk("step_halt", halt, 0);
            tick(1);
            chk("step_back", state, 0);
            chk("step_count", instr_count, k);
            release_all();
            chk("step_idle_count", instr_count, k);
        end

        // Breakpoint and resume past it
        do_reset();
        bp_en = 1'b1; bp_addr = 32'h10; pc_cur = 32'h0;
        btn_run = 1'b1;
        tick(7);
        chk("bp_run", state, 1);
        release_all();
        chk("bp_count8", instr_count, 8);
        pc_cur = 32'h10;
        #1;
        chk("bp_halt_same", halt, 1);
        tick(1);
        chk("bp_state", state, 3);
        chk("bp_count_hold", instr_count, 8);
        btn_run = 1'b1;
        tick(6);
        chk("bp_wait", state, 3);
        tick(1);
        chk("bp_resume", state, 1);
        chk("bp_skip_halt", halt, 0);
        tick(1);
        chk("bp_skip_count", instr_count, 9);
        pc_cur = 32'h14;
        #1;
        chk("bp_after_halt", halt, 0);
        release_all();
        chk("bp_run_state", state, 1);
        chk("bp_count17", instr_count, 17);

        // Halt opcode: DONE ignores all buttons
        pc_cur = 32'h24; halt_insn = 1'b1;
        #1;
        chk("done_halt_same", halt, 1);
        tick(1);
        chk("done_state", state, 4);
        btn_run = 1'b1;  tick(7); chk("done_run_ign", state, 4);  release_all();
        btn_step = 1'b1; tick(7); chk("done_step_ign", state, 4); release_all();
        btn_stop = 1'b1; tick(7); chk("done_stop_ign", state, 4); release_all();
        chk("done_halt", halt, 1);
        chk("done_count", instr_count, 17);
        Reset = 1'b1;
        tick(1);
        chk("done_rst_state", state, 0);
        chk("done_rst_count", instr_count, 0);
        Reset = 1'b0;
        halt_insn = 1'b0; bp_en = 1'b0; pc_cur = 32'h0;

        // Stop+run together in RUN, then run+step together from HALTED
        do_reset();
        btn_run = 1'b1;
        tick(7);
        chk("sr_run", state, 1);
        release_all();
        btn_run = 1'b1; btn_stop = 1'b1;
        tick(6);
        chk("sr_halt_pulse", halt, 1);
        tick(1);
        chk("sr_stopped", state, 0);
        release_all();
        btn_run = 1'b1; btn_step = 1'b1;
        tick(7);
        chk("rs_run_wins", state, 1);
        release_all();

        // Counter wrap
        do_reset();
        btn_run = 1'b1;
        tick(7);
        chk("wrap_run", state, 1);
        btn_run = 1'b0;
        tick(65534);
        chk("wrap_fffe", instr_count, 16'hFFFE);
        tick(1);
        chk("wrap_ffff", instr_count, 16'hFFFF);
        tick(1);
        chk("wrap_zero", instr_count, 16'h0000);
        tick(8);

        // Reset mid-step
        do_reset();
        btn_step = 1'b1;
        tick(7);
        chk("ms_step", state, 2);
        chk("ms_halt0", halt, 0);
        Reset = 1'b1;
        tick(1);
        chk("ms_state", state, 0);
        chk("ms_halt", halt, 1);
        chk("ms_count", instr_count, 0);
        Reset = 1'b0;
        btn_step = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
